// File: rtl/rx_serial_7e1.sv
// rx_serial_7e1 -- asynchronous 7E1 serial receiver
//
// Receives 1 start bit, 7 data bits LSB first, 1 even-parity bit and 1 stop
// bit. Every bit is sampled at its middle, timed from the detected start edge.
// Each completed word is held in a one-deep buffer. The buffer has a read
// handshake and a sticky overrun flag.
//
// Build option:
//   RX_PARITY_CHECK_EN  defined   : erro_paridade reports the even-parity check
//                       undefined : the parity bit is still sampled so that
//                                   frame timing is unchanged; erro_paridade
//                                   is tied to 0 and no parity logic exists.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-high; clears all state
//   RX             in   serial line, idle high, asynchronous to clock
//   ler            in   consumer acknowledge; clears disponivel
//   dados[6:0]     out  last accepted word
//   pronto         out  one-cycle pulse while a frame is delivered
//   disponivel     out  buffer holds an unread word
//   erro_paridade  out  parity error of the last frame
//   erro_stop      out  stop bit of the last frame was sampled low
//   overrun        out  sticky: an unread word was overwritten
//   ocupado        out  a frame is in progress
//
// state    | meaning
// ---------+-----------------------------------------------------------
// OCIOSO   | idle, counters at 0, waiting for a 1->0 edge on rx_s
// INICIO   | timing to the start-bit middle; rx_s=1 there means a glitch
// DADOS    | sampling data bits 0..6, one every BAUD_DIV cycles
// PARIDADE | sampling the parity bit
// PARADA   | sampling the stop bit
// ENTREGA  | one cycle: pronto high; word and flags land at its closing edge
module rx_serial_7e1 #(
  parameter int BAUD_DIV = 434,
  parameter int HALF_DIV = 217
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  input  logic       ler,
  output logic [6:0] dados,
  output logic       pronto,
  output logic       disponivel,
  output logic       erro_paridade,
  output logic       erro_stop,
  output logic       overrun,
  output logic       ocupado
);

  localparam int TW = $clog2(BAUD_DIV + 1);

  typedef enum logic [2:0] {
    OCIOSO,
    INICIO,
    DADOS,
    PARIDADE,
    PARADA,
    ENTREGA
  } estado_t;

  estado_t       estado;
  estado_t       estado_prox;

  logic          rx_m;
  logic          rx_s;
  logic          rx_d;
  logic          rx_queda;
  logic [TW-1:0] tick;
  logic          tick_tc;
  logic [2:0]    bit_idx;
  logic [6:0]    desloc;
  logic          stop_ruim;

  // Two-flop synchronizer. rx_d holds the previous rx_s for edge detection.
  // All three flops reset to the idle level so that reset never fakes a start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign rx_queda = rx_d & ~rx_s;

  // The bit timer is a down-counter. A sample is taken on the edge where it
  // reads 1. Loading N on edge E therefore samples on edge E+N.
  assign tick_tc = (tick == TW'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:   if (rx_queda) estado_prox = INICIO;
      INICIO:   if (tick_tc)  estado_prox = rx_s ? OCIOSO : DADOS;
      DADOS:    if (tick_tc && (bit_idx == 3'd6)) estado_prox = PARIDADE;
      PARIDADE: if (tick_tc)  estado_prox = PARADA;
      PARADA:   if (tick_tc)  estado_prox = ENTREGA;
      ENTREGA:  estado_prox = OCIOSO;
      default:  estado_prox = OCIOSO;
    endcase
  end

  // The edge is seen one cycle after rx_s first reads 0, so the start-bit
  // middle is reached HALF_DIV-1 cycles after entering INICIO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick <= '0;
    end else begin
      case (estado)
        OCIOSO: tick <= rx_queda ? TW'(HALF_DIV - 1) : '0;
        INICIO, DADOS, PARIDADE, PARADA: begin
          if (tick_tc) begin
            if ((estado_prox == OCIOSO) || (estado_prox == ENTREGA)) begin
              tick <= '0;
            end else begin
              tick <= TW'(BAUD_DIV);
            end
          end else begin
            tick <= tick - TW'(1);
          end
        end
        default: tick <= '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_idx   <= '0;
      desloc    <= '0;
      stop_ruim <= 1'b0;
    end else begin
      if ((estado == DADOS) && tick_tc) begin
        desloc  <= {rx_s, desloc[6:1]};
        bit_idx <= (bit_idx == 3'd6) ? 3'd0 : bit_idx + 3'd1;
      end else if (estado == OCIOSO) begin
        bit_idx <= '0;
      end
      if ((estado == PARADA) && tick_tc) begin
        stop_ruim <= ~rx_s;
      end
    end
  end

  // A delivery sets disponivel even when ler arrives in the same cycle.
  // That ler read the previous word, so it does not count as an overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dados      <= '0;
      erro_stop  <= 1'b0;
      disponivel <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (estado == ENTREGA) begin
        dados      <= desloc;
        erro_stop  <= stop_ruim;
        disponivel <= 1'b1;
        if (disponivel && !ler) begin
          overrun <= 1'b1;
        end
      end else if (ler) begin
        disponivel <= 1'b0;
      end
    end
  end

`ifdef RX_PARITY_CHECK_EN
  logic par_ruim;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_ruim      <= 1'b0;
      erro_paridade <= 1'b0;
    end else begin
      if ((estado == PARIDADE) && tick_tc) begin
        par_ruim <= rx_s ^ (^desloc);
      end
      if (estado == ENTREGA) begin
        erro_paridade <= par_ruim;
      end
    end
  end
`else
  assign erro_paridade = 1'b0;
`endif

  assign pronto  = (estado == ENTREGA);
  assign ocupado = (estado != OCIOSO);

endmodule
